// File: rtl/zero_count_pkg.sv
// Shared types and helpers for the iterative zero-count scanner.
// Holds FSM state encoding, mode encoding and count-width helper.
package zero_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic MODE_TRAILING = 1'b0;
  localparam logic MODE_LEADING  = 1'b1;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/zero_count_chunk.sv
// Combinational trailing-zero counter for one scan chunk.
// An all-zero chunk reports WIDTH with nonzero low.
module zero_count_chunk
  import zero_count_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        chunk,
  output logic [$clog2(WIDTH):0]  count,
  output logic                    nonzero
);

  localparam int TW = $clog2(WIDTH) + 1;

  always_comb begin
    count = TW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (chunk[i]) count = TW'(i);
    end
  end

  assign nonzero = |chunk;

endmodule

// File: rtl/zero_count_scanner.sv
// Handshaked leading/trailing zero counter scanning one chunk per cycle.
// Stops at the first nonzero chunk; all-zero operands raise dout_zero.
module zero_count_scanner
  import zero_count_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH,
  localparam int CW         = count_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  mode,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CW-1:0]         dout,
  output logic                  dout_zero
);

  localparam int KW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int TW  = $clog2(CHUNK_WIDTH) + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(NUM_CHUNKS - 1);
  localparam logic [CW-1:0] CHUNK_C = CW'(CHUNK_WIDTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] operand;
  logic                  scan_mode;
  logic [KW-1:0]         k;

  logic [CHUNK_WIDTH-1:0] raw;
  logic [CHUNK_WIDTH-1:0] sel;
  logic [TW-1:0]          count;
  logic                   nonzero;

  assign din_ready = (state == IDLE) && !reset;

  // Leading mode walks slices from the MSB and mirrors each one
  // so a single trailing-zero counter serves both directions.
  always_comb begin
    raw = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (KW'(c) == k) begin
        if (scan_mode == MODE_LEADING)
          raw = operand[(NUM_CHUNKS-1-c)*CHUNK_WIDTH +: CHUNK_WIDTH];
        else
          raw = operand[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
    sel = raw;
    if (scan_mode == MODE_LEADING) begin
      for (int b = 0; b < CHUNK_WIDTH; b++)
        sel[b] = raw[CHUNK_WIDTH-1-b];
    end
  end

  zero_count_chunk #(
    .WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .chunk   (sel),
    .count   (count),
    .nonzero (nonzero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      operand    <= '0;
      scan_mode  <= MODE_TRAILING;
      k          <= '0;
      dout       <= '0;
      dout_zero  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) begin
            operand   <= din;
            scan_mode <= mode;
            k         <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (nonzero) begin
            dout       <= CW'(k) * CHUNK_C + CW'(count);
            dout_zero  <= 1'b0;
            dout_valid <= 1'b1;
            state      <= DONE;
          end else if (k == K_LAST) begin
            dout       <= FULL_C;
            dout_zero  <= 1'b1;
            dout_valid <= 1'b1;
            state      <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_scanner.sv
// Directed self-checking bench for zero_count_scanner (32-bit, 8-bit chunks).
// Each task drives one scenario and checks results against hand values.
module tb_zero_count_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din;
  logic        mode;
  logic        dout_valid;
  logic        dout_ready;
  logic [5:0]  dout;
  logic        dout_zero;

  int tests = 0;
  int fails = 0;

  zero_count_scanner #(
    .DATA_WIDTH  (32),
    .CHUNK_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .mode       (mode),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_zero  (dout_zero)
  );

  always #5 clk = ~clk;

  // Present one operand for one edge, then wait (bounded) for dout_valid.
  // lat = cycles from accept edge to dout_valid, -1 on timeout.
  task automatic send(input logic [31:0] d, input logic m, output int lat);
    din = d;
    mode = m;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = ~d;
    mode = ~m;
    lat = 0;
    while (dout_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (dout_valid !== 1'b1) lat = -1;
  endtask

  task automatic take();
    dout_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    din = '0;
    mode = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (din_ready !== 1'b0) begin
      fails++; $display("FAIL rst_din_ready got=%b exp=0", din_ready);
    end
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++; $display("FAIL rst_dout_valid got=%b exp=0", dout_valid);
    end
    tests++;
    if (dout !== 6'd0) begin
      fails++; $display("FAIL rst_dout got=%0d exp=0", dout);
    end
    tests++;
    if (dout_zero !== 1'b0) begin
      fails++; $display("FAIL rst_dout_zero got=%b exp=0", dout_zero);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (din_ready !== 1'b1) begin
      fails++; $display("FAIL rst_release_ready got=%b exp=1", din_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_trailing();
    logic [31:0] v [2] = '{32'h0000_0001, 32'h0010_0000};
    int          e [2] = '{0, 20};
    int          l [2] = '{1, 3};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(v[i], 1'b0, lat);
      tests++;
      if (dout !== 6'(e[i]) || dout_zero !== 1'b0) begin
        fails++;
        $display("FAIL trail_%0d got=%0d/%b exp=%0d/0", i, dout, dout_zero, e[i]);
      end
      tests++;
      if (lat !== l[i]) begin
        fails++; $display("FAIL trail_lat_%0d got=%0d exp=%0d", i, lat, l[i]);
      end
      take();
      tests++;
      if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL trail_idle_%0d got rdy=%b vld=%b exp rdy=1 vld=0",
                 i, din_ready, dout_valid);
      end
    end
  endtask

  task automatic test_all_zero();
    int lat;
    for (int m = 0; m < 2; m++) begin
      send(32'h0, 1'(m), lat);
      tests++;
      if (dout !== 6'd32 || dout_zero !== 1'b1) begin
        fails++;
        $display("FAIL zero_m%0d got=%0d/%b exp=32/1", m, dout, dout_zero);
      end
      tests++;
      if (lat !== 4) begin
        fails++; $display("FAIL zero_lat_m%0d got=%0d exp=4", m, lat);
      end
      take();
    end
  endtask

  task automatic test_leading();
    logic [31:0] v [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000};
    logic        m [3] = '{1'b1, 1'b0, 1'b1};
    int          e [3] = '{0, 31, 15};
    int          l [3] = '{1, 4, 2};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(v[i], m[i], lat);
      tests++;
      if (dout !== 6'(e[i]) || dout_zero !== 1'b0) begin
        fails++;
        $display("FAIL lead_%0d got=%0d/%b exp=%0d/0", i, dout, dout_zero, e[i]);
      end
      tests++;
      if (lat !== l[i]) begin
        fails++; $display("FAIL lead_lat_%0d got=%0d exp=%0d", i, lat, l[i]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    dout_ready = 1'b0;
    send(32'h0000_0100, 1'b0, lat);
    tests++;
    if (dout !== 6'd8 || lat !== 2) begin
      fails++; $display("FAIL bp_result got=%0d lat=%0d exp=8 lat=2", dout, lat);
    end
    for (int c = 0; c < 5; c++) begin
      din = 32'hFFFF_FFFF ^ 32'(c);
      mode = 1'(c);
      din_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (dout_valid !== 1'b1 || dout !== 6'd8 || dout_zero !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d got vld=%b dout=%0d z=%b exp 1/8/0",
                 c, dout_valid, dout, dout_zero);
      end
      tests++;
      if (din_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready_%0d got=%b exp=0", c, din_ready);
      end
    end
    din_valid = 1'b0;
    take();
    tests++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0",
               din_ready, dout_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    din = 32'h0;
    mode = 1'b0;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (dout_valid !== 1'b0 || dout !== 6'd0 || dout_zero !== 1'b0) begin
      fails++;
      $display("FAIL rmid_clear got vld=%b dout=%0d z=%b exp 0/0/0",
               dout_valid, dout, dout_zero);
    end
    tests++;
    if (din_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_ready_in_reset got=%b exp=0", din_ready);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (din_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_ready_after got=%b exp=1", din_ready);
    end
    send(32'h0000_0004, 1'b0, lat);
    tests++;
    if (dout !== 6'd2 || dout_zero !== 1'b0 || lat !== 1) begin
      fails++;
      $display("FAIL rmid_after got=%0d/%b lat=%0d exp=2/0 lat=1",
               dout, dout_zero, lat);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(32'h0000_0200, 1'b0, lat);
    tests++;
    if (dout !== 6'd9 || lat !== 2) begin
      fails++; $display("FAIL b2b_first got=%0d lat=%0d exp=9 lat=2", dout, lat);
    end
    take();
    send(32'h0040_0000, 1'b1, lat);
    tests++;
    if (dout !== 6'd9 || lat !== 2) begin
      fails++; $display("FAIL b2b_second got=%0d lat=%0d exp=9 lat=2", dout, lat);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_trailing();
    test_all_zero();
    test_leading();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
